// File: rtl/pvz_pkg.sv
// pvz_pkg: shared geometry and FSM encoding for the pea engine.
// Rev 1.0
`default_nettype none
package pvz_pkg;
  localparam int NUM_LANES      = 5;
  localparam int SLOTS_PER_LANE = 5;
  localparam int X_W            = 10;
  localparam int NUM_SLOTS      = NUM_LANES * SLOTS_PER_LANE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;
endpackage
`default_nettype wire

// File: rtl/pea_lane.sv
// pea_lane: five pea slots of one lane with allocation, hit/motion and fire cooldown.
// Rev 1.0
`default_nettype none
module pea_lane
  import pvz_pkg::*;
#(
  parameter logic [X_W-1:0] SHOOTER_X      = 10'd100,
  parameter logic [X_W-1:0] SCREEN_RIGHT   = 10'd799,
  parameter int             COOLDOWN_TICKS = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            tick,
  input  logic                            accept,
  input  logic [SLOTS_PER_LANE-1:0]       hit,
  output logic                            ready,
  output logic [SLOTS_PER_LANE-1:0]       active,
  output logic [SLOTS_PER_LANE*X_W-1:0]   x
);
  localparam int             CW        = $clog2(COOLDOWN_TICKS + 2);
  localparam logic [CW-1:0]  COOL_LOAD = CW'(COOLDOWN_TICKS);
  localparam logic [X_W-1:0] RETIRE_X  = SCREEN_RIGHT - X_W'(1);

  logic [CW-1:0]             cooldown;
  logic [SLOTS_PER_LANE-1:0] alloc;

  // Lowest clear bit of the registered occupancy, one-hot; zero when the lane is full.
  assign alloc = ~active & (active + SLOTS_PER_LANE'(1));
  assign ready = (|(~active)) && (cooldown == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cooldown <= '0;
    end else if (flush) begin
      cooldown <= '0;
    end else if (accept) begin
      cooldown <= COOL_LOAD;
    end else if (tick && (cooldown != '0)) begin
      cooldown <= cooldown - CW'(1);
    end
  end

  for (genvar s = 0; s < SLOTS_PER_LANE; s++) begin : g_slot
    logic           act_r;
    logic [X_W-1:0] x_r;

    // Priority: flush, new pea, hit, then motion/retirement.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        act_r <= 1'b0;
        x_r   <= '0;
      end else if (flush) begin
        act_r <= 1'b0;
        x_r   <= '0;
      end else if (accept && alloc[s]) begin
        act_r <= 1'b1;
        x_r   <= SHOOTER_X;
      end else if (act_r && hit[s]) begin
        act_r <= 1'b0;
        x_r   <= '0;
      end else if (act_r && tick) begin
        if (x_r >= RETIRE_X) begin
          act_r <= 1'b0;
          x_r   <= '0;
        end else begin
          x_r <= x_r + X_W'(1);
        end
      end
    end

    assign active[s]          = act_r;
    assign x[s*X_W +: X_W]    = x_r;
  end
endmodule
`default_nettype wire

// File: rtl/pea_engine.sv
// pea_engine: level FSM, motion tick divider, fire decode and shot counter over five lanes.
// Rev 1.0
`default_nettype none
module pea_engine
  import pvz_pkg::*;
#(
  parameter int             TICK_DIV       = 250000,
  parameter logic [X_W-1:0] SHOOTER_X      = 10'd100,
  parameter logic [X_W-1:0] SCREEN_RIGHT   = 10'd799,
  parameter int             COOLDOWN_TICKS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic                       fire_valid,
  input  logic [2:0]                 fire_lane,
  output logic                       fire_ready,
  input  logic [NUM_SLOTS-1:0]       hit,
  output logic [NUM_SLOTS-1:0]       pea_active,
  output logic [NUM_SLOTS*X_W-1:0]   pea_x,
  output logic [15:0]                shots_fired
);
  localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic                   in_run;
  logic                   in_flush;
  logic [TW-1:0]          tick_cnt;
  logic                   tick;
  logic [NUM_LANES-1:0]   lane_sel;
  logic [NUM_LANES-1:0]   lane_ready;
  logic [NUM_LANES-1:0]   lane_accept;
  logic [NUM_SLOTS-1:0]   hit_run;
  logic                   fire_take;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (run)  state_nxt = ST_RUN;
      ST_RUN:   if (!run) state_nxt = ST_FLUSH;
      ST_FLUSH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_run   = (state == ST_RUN);
    in_flush = (state == ST_FLUSH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (in_flush) begin
      tick_cnt <= '0;
    end else if (in_run) begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
    end
  end

  assign tick = in_run && (tick_cnt == TICK_LAST);

  // Lane codes 5..7 select nothing, which keeps fire_ready low for them.
  always_comb begin
    lane_sel = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_sel[l] = (fire_lane == 3'(l));
    end
  end

  assign fire_ready  = in_run && (|(lane_sel & lane_ready));
  assign fire_take   = fire_valid && fire_ready;
  assign lane_accept = lane_sel & {NUM_LANES{fire_take}};
  assign hit_run     = hit & {NUM_SLOTS{in_run}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shots_fired <= '0;
    end else if (fire_take && (shots_fired != 16'hFFFF)) begin
      shots_fired <= shots_fired + 16'd1;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    pea_lane #(
      .SHOOTER_X      (SHOOTER_X),
      .SCREEN_RIGHT   (SCREEN_RIGHT),
      .COOLDOWN_TICKS (COOLDOWN_TICKS)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .flush  (in_flush),
      .tick   (tick),
      .accept (lane_accept[l]),
      .hit    (hit_run[l*SLOTS_PER_LANE +: SLOTS_PER_LANE]),
      .ready  (lane_ready[l]),
      .active (pea_active[l*SLOTS_PER_LANE +: SLOTS_PER_LANE]),
      .x      (pea_x[l*SLOTS_PER_LANE*X_W +: SLOTS_PER_LANE*X_W])
    );
  end
endmodule
`default_nettype wire

// File: tb/tb_pea_engine.sv
// tb_pea_engine: table vectors, directed corner sequences and random stimulus vs a slot-array model.
// Rev 1.0
`default_nettype none
module tb_pea_engine;
  localparam int TICK_DIV  = 4;
  localparam int COOL      = 2;
  localparam int SHOOT_X   = 100;
  localparam int SCR_RIGHT = 110;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         run = 1'b0;
  logic         fire_valid = 1'b0;
  logic [2:0]   fire_lane = 3'd0;
  logic         fire_ready;
  logic [24:0]  hit = '0;
  logic [24:0]  pea_active;
  logic [249:0] pea_x;
  logic [15:0]  shots_fired;

  int checks = 0;
  int failures = 0;
  logic seen_ready;

  pea_engine #(
    .TICK_DIV       (TICK_DIV),
    .SHOOTER_X      (10'd100),
    .SCREEN_RIGHT   (10'd110),
    .COOLDOWN_TICKS (COOL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .fire_valid  (fire_valid),
    .fire_lane   (fire_lane),
    .fire_ready  (fire_ready),
    .hit         (hit),
    .pea_active  (pea_active),
    .pea_x       (pea_x),
    .shots_fired (shots_fired)
  );

  always #5 clk = ~clk;

  // Behavioural model: 0=idle 1=run 2=flush
  int m_state, m_cnt, m_shots;
  bit m_act[25];
  int m_x[25];
  int m_cd[5];

  function automatic void m_reset();
    m_state = 0; m_cnt = 0; m_shots = 0;
    for (int i = 0; i < 25; i++) begin m_act[i] = 0; m_x[i] = 0; end
    for (int l = 0; l < 5; l++) m_cd[l] = 0;
  endfunction

  function automatic bit m_ready(logic [2:0] fl);
    int ln;
    ln = int'(fl);
    if (m_state != 1 || ln > 4 || m_cd[ln] != 0) return 0;
    for (int s = 0; s < 5; s++) if (!m_act[ln*5+s]) return 1;
    return 0;
  endfunction

  function automatic void m_clock(logic r, logic fv, logic [2:0] fl, logic [24:0] h);
    bit acc, tk;
    int slot, ln;
    ln   = int'(fl);
    acc  = fv && m_ready(fl);
    tk   = (m_state == 1) && (m_cnt == TICK_DIV - 1);
    slot = -1;
    if (m_state == 2) begin
      for (int i = 0; i < 25; i++) begin m_act[i] = 0; m_x[i] = 0; end
      for (int l = 0; l < 5; l++) m_cd[l] = 0;
      m_cnt = 0;
    end else if (m_state == 1) begin
      if (acc) begin
        for (int s = 4; s >= 0; s--) if (!m_act[ln*5+s]) slot = ln*5 + s;
        if (m_shots < 65535) m_shots++;
      end
      for (int i = 0; i < 25; i++) begin
        if (i == slot) begin
          m_act[i] = 1; m_x[i] = SHOOT_X;
        end else if (m_act[i] && h[i]) begin
          m_act[i] = 0; m_x[i] = 0;
        end else if (m_act[i] && tk) begin
          if (m_x[i] >= SCR_RIGHT - 1) begin m_act[i] = 0; m_x[i] = 0; end
          else m_x[i]++;
        end
      end
      for (int l = 0; l < 5; l++) begin
        if (acc && l == ln) m_cd[l] = COOL;
        else if (tk && m_cd[l] > 0) m_cd[l]--;
      end
      m_cnt = tk ? 0 : m_cnt + 1;
    end
    case (m_state)
      0: if (r) m_state = 1;
      1: if (!r) m_state = 2;
      default: m_state = 0;
    endcase
  endfunction

  function automatic logic [24:0] m_actv();
    logic [24:0] v;
    for (int i = 0; i < 25; i++) v[i] = m_act[i];
    return v;
  endfunction

  function automatic logic [249:0] m_xv();
    logic [249:0] v;
    for (int i = 0; i < 25; i++) v[i*10 +: 10] = 10'(m_x[i]);
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic fv, input logic [2:0] fl, input logic [24:0] h);
    logic er;
    run = r; fire_valid = fv; fire_lane = fl; hit = h;
    #1;
    er = m_ready(fl);
    seen_ready = fire_ready;
    chk("fire_ready", 256'(fire_ready), 256'(er));
    @(posedge clk);
    m_clock(r, fv, fl, h);
    #1;
    chk("pea_active", 256'(pea_active), 256'(m_actv()));
    chk("pea_x", 256'(pea_x), 256'(m_xv()));
    chk("shots_fired", 256'(shots_fired), 256'(m_shots));
  endtask

  task automatic do_reset();
    reset = 1'b0; run = 0; fire_valid = 0; fire_lane = 0; hit = '0;
    @(posedge clk);
    #1;
    m_reset();
    chk("reset_active", 256'(pea_active), 256'(0));
    chk("reset_x", 256'(pea_x), 256'(0));
    chk("reset_shots", 256'(shots_fired), 256'(0));
    chk("reset_ready", 256'(fire_ready), 256'(0));
    reset = 1'b1;
  endtask

  typedef struct {
    logic        run;
    logic        fv;
    logic [2:0]  lane;
    logic        exp_ready;
    logic [24:0] exp_act;
    logic [9:0]  exp_x10;
    logic [15:0] exp_shots;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int waits, accepted;
    tbl[0] = '{1'b1, 1'b0, 3'd0, 1'b0, 25'h0,   10'd0,   16'd0};
    tbl[1] = '{1'b1, 1'b1, 3'd2, 1'b1, 25'h400, 10'd100, 16'd1};
    tbl[2] = '{1'b1, 1'b0, 3'd2, 1'b0, 25'h400, 10'd100, 16'd1};
    tbl[3] = '{1'b1, 1'b0, 3'd2, 1'b0, 25'h400, 10'd100, 16'd1};
    tbl[4] = '{1'b1, 1'b0, 3'd2, 1'b0, 25'h400, 10'd101, 16'd1};
    tbl[5] = '{1'b1, 1'b1, 3'd5, 1'b0, 25'h400, 10'd101, 16'd1};
    tbl[6] = '{1'b0, 1'b0, 3'd2, 1'b0, 25'h400, 10'd101, 16'd1};
    tbl[7] = '{1'b0, 1'b1, 3'd0, 1'b0, 25'h0,   10'd0,   16'd1};
    tbl[8] = '{1'b0, 1'b1, 3'd0, 1'b0, 25'h0,   10'd0,   16'd1};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].run, tbl[i].fv, tbl[i].lane, '0);
      chk($sformatf("tbl%0d_ready", i), 256'(seen_ready), 256'(tbl[i].exp_ready));
      chk($sformatf("tbl%0d_act", i), 256'(pea_active), 256'(tbl[i].exp_act));
      chk($sformatf("tbl%0d_x10", i), 256'(pea_x[109:100]), 256'(tbl[i].exp_x10));
      chk($sformatf("tbl%0d_shots", i), 256'(shots_fired), 256'(tbl[i].exp_shots));
    end

    // Free-running pea reaches the last column then retires.
    do_reset();
    step(1, 0, 0, '0);
    step(1, 1, 2, '0);
    for (int i = 0; i < 35; i++) step(1, 0, 0, '0);
    chk("retire_x109", 256'(pea_x[109:100]), 256'(109));
    chk("retire_act_before", 256'(pea_active[10]), 256'(1));
    for (int i = 0; i < 4; i++) step(1, 0, 0, '0);
    chk("retire_act_after", 256'(pea_active[10]), 256'(0));
    chk("retire_x_after", 256'(pea_x[109:100]), 256'(0));

    // Back-to-back fires in lane 0 are held off by the cooldown.
    do_reset();
    step(1, 0, 0, '0);
    step(1, 1, 0, '0);
    chk("cool_first_ready", 256'(seen_ready), 256'(1));
    waits = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, '0);
      if (seen_ready) break;
      waits++;
    end
    chk("cool_wait_cycles", 256'(waits), 256'(7));
    chk("cool_slot1_act", 256'(pea_active[1:0]), 256'(2'b11));
    chk("cool_slot1_x", 256'(pea_x[19:10]), 256'(100));

    // Fill lane 4, free slot 20 with a hit, refill it.
    do_reset();
    step(1, 0, 0, '0);
    accepted = 0;
    for (int i = 0; i < 100 && accepted < 5; i++) begin
      step(1, 1, 4, '0);
      if (seen_ready) accepted++;
    end
    chk("full_accepts", 256'(accepted), 256'(5));
    chk("full_lane4_act", 256'(pea_active[24:20]), 256'(5'h1f));
    step(1, 1, 4, 25'h1 << 20);
    chk("full_ready_after", 256'(seen_ready), 256'(0));
    chk("hit20_cleared", 256'(pea_active[24:20]), 256'(5'h1e));
    waits = 0;
    while (!seen_ready && waits < 20) begin
      step(1, 1, 4, '0);
      waits++;
    end
    chk("refill_bound", 256'(seen_ready), 256'(1));
    chk("refill_act20", 256'(pea_active[20]), 256'(1));
    chk("refill_x20", 256'(pea_x[209:200]), 256'(100));

    // Asynchronous reset between edges while peas are in flight.
    do_reset();
    step(1, 0, 0, '0);
    step(1, 1, 1, '0);
    step(1, 1, 3, '0);
    run = 1; fire_valid = 1; fire_lane = 3'd0;
    #2 reset = 1'b0;
    #1;
    chk("async_active", 256'(pea_active), 256'(0));
    chk("async_x", 256'(pea_x), 256'(0));
    chk("async_shots", 256'(shots_fired), 256'(0));
    chk("async_ready", 256'(fire_ready), 256'(0));
    m_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    step(1, 1, 0, '0);
    chk("async_idle_ready", 256'(seen_ready), 256'(0));

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           25'($urandom & $urandom & $urandom & $urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pea_engine.md
PEA_ENGINE -- requirements
Module: pea_engine

Interface
REQ-001 SHALL have parameter TICK_DIV, default 250000, clocks per pea motion tick.
REQ-002 SHALL have parameter SHOOTER_X, default 10'd100, spawn x of a new pea.
REQ-003 SHALL have parameter SCREEN_RIGHT, default 10'd799, x at which a pea retires.
REQ-004 SHALL have parameter COOLDOWN_TICKS, default 8, minimum ticks between fires in one lane.
REQ-005 SHALL have port clk  in  1  sole clock; all state on posedge clk.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port run  in  1  level; 1 while a level is being played.
REQ-008 SHALL have port fire_valid  in  1  fire request.
REQ-009 SHALL have port fire_lane  in  3  target lane, 0..4.
REQ-010 SHALL have port fire_ready  out  1  combinational; request accepted when fire_valid&&fire_ready.
REQ-011 SHALL have port hit  in  25  one-cycle pulse per slot; bit 5*lane+slot.
REQ-012 SHALL have port pea_active  out  25  slot occupied.
REQ-013 SHALL have port pea_x  out  250  packed x; slot k at bits [10k+9:10k].
REQ-014 SHALL have port shots_fired  out  16  accepted fires since reset.

Function
REQ-015 SHALL implement states IDLE, RUN, FLUSH; IDLE->RUN when run=1; RUN->FLUSH when run=0; FLUSH->IDLE unconditionally after one cycle.
REQ-016 SHALL clear all slots, all lane cooldowns and the tick counter during FLUSH; shots_fired is retained.
REQ-017 SHALL count clocks 0..TICK_DIV-1 only in RUN, asserting an internal tick for one cycle at count TICK_DIV-1, then wrapping to 0.
REQ-018 SHALL on tick add 1 to x of every active slot not hit that cycle; a slot whose pre-increment x >= SCREEN_RIGHT-1 SHALL go inactive instead.
REQ-019 SHALL drive fire_ready=1 only in RUN, fire_lane<=4, lane has a free slot, and lane cooldown is 0; otherwise 0.
REQ-020 SHALL place an accepted fire in the lowest-index free slot of the lane, x=SHOOTER_X, active next cycle; that pea is not moved on a tick coinciding with acceptance.
REQ-021 SHALL load lane cooldown with COOLDOWN_TICKS on acceptance and decrement it by 1 per tick down to 0.
REQ-022 SHALL clear a slot on its hit bit the following cycle; hit overrides motion; hit on an inactive slot is ignored.
REQ-023 SHALL compute free slots from registered state, so a slot freed by hit is allocatable no earlier than the next cycle.
REQ-024 SHALL saturate shots_fired at 16'hFFFF.
REQ-025 SHALL hold inactive slots at pea_x=0.
REQ-026 SHALL ignore fire_valid and hit outside RUN.

Reset
REQ-027 SHALL on reset=0, asynchronously: state=IDLE, pea_active=0, all pea_x=0, cooldowns=0, tick counter=0, shots_fired=0; hence fire_ready=0.
REQ-028 SHALL abandon any in-flight peas if reset asserts mid-RUN, resuming in IDLE after release.

Structure
REQ-029 SHALL take NUM_LANES=5, SLOTS_PER_LANE=5, X width 10, and the state encoding from shared package pvz_pkg.
REQ-030 SHALL instantiate sub-module pea_lane five times, each owning 5 slots, its cooldown, allocation and hit/motion logic; pea_engine owns FSM, tick counter, lane decode and shots_fired.

Verification (TICK_DIV=4, COOLDOWN_TICKS=2, SCREEN_RIGHT=110 overrides)
REQ-031 SHALL cover: reset, run=1, fire lane 2 -> pea_active[10]=1, pea_x slot10=100, shots_fired=1, x=101 after next tick.
REQ-032 SHALL cover: pea free-runs -> x reaches 109, retires on next tick, pea_active[10]=0, pea_x=0.
REQ-033 SHALL cover: fire lane 0 twice back-to-back -> second held off (fire_ready=0) until 2 ticks elapse, then lands in slot 1.
REQ-034 SHALL cover: 5 accepted fires in lane 4 -> fire_ready=0 for lane 4; hit[20] pulse -> slot 20 freed, next fire refills slot 20.
REQ-035 SHALL cover: fire_lane=5 or run=0 -> fire_ready=0; run 1->0 with 3 active peas -> FLUSH one cycle, pea_active=0, shots_fired unchanged.
REQ-036 SHALL cover: reset asserted mid-RUN between clock edges -> outputs zero immediately, state IDLE.
